// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: 2-flop sync, per-bit debounce,
// sticky edge flags with write-1-to-clear and an IRQ summary.
module gpio_in_conditioner #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] clr,
  output logic [7:0] gpio_in,
  output logic [7:0] rise_flags,
  output logic [7:0] fall_flags,
  output logic       irq
);

  localparam logic [7:0] DB_MAX = 8'(DB_CYCLES - 1);

  logic [7:0]      sync1_q;
  logic [7:0]      sync2_q;
  logic [7:0]      stable_q;
  logic [7:0]      stable_d;
  logic [7:0][7:0] cnt_q;
  logic [7:0][7:0] cnt_d;
  logic [7:0]      rise_q;
  logic [7:0]      rise_d;
  logic [7:0]      fall_q;
  logic [7:0]      fall_d;
  logic [7:0]      set_rise;
  logic [7:0]      set_fall;

  // Two-flop synchronizer for the raw pad inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ui_in;
      sync2_q <= sync2_d();
    end
  end

  function automatic logic [7:0] sync2_d();
    return sync1_q;
  endfunction

  // Per-bit debounce: count consecutive disagreeing samples
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 8; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Edge events; a set on the same edge as clr wins
  always_comb begin
    set_rise = stable_d & ~stable_q;
    set_fall = ~stable_d & stable_q;
    rise_d   = set_rise | (rise_q & ~clr);
    fall_d   = set_fall | (fall_q & ~clr);
  end

  // Debounce and flag state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign gpio_in    = stable_q;
  assign rise_flags = rise_q;
  assign fall_flags = fall_q;
  assign irq        = |(rise_q | fall_q);

endmodule
